// File: rtl/svc_soc_io_arb_pkg.sv
// Shared types for the SOC I/O bus arbiter: the registered command
// bundle and the owner-index width helper.
package svc_soc_io_arb_pkg;

    localparam int unsigned IO_AW = 32;
    localparam int unsigned IO_DW = 32;

    typedef struct packed {
        logic                 write;
        logic [IO_AW-1:0]     addr;
        logic [IO_DW-1:0]     wdata;
        logic [IO_DW/8-1:0]   wstrb;
    } io_cmd_t;

    // Width of an index into n requesters, never narrower than 1 bit.
    function automatic int unsigned owner_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svc_soc_io_arbiter_rr.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports: clk, rst_n (sync, active-low), req, advance -> grant, grant_idx.
module svc_rr_arbiter
    import svc_soc_io_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW = owner_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;

    // Search upward from the pointer, wrapping at NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            int j;
            j = int'(ptr_q) + k;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (grant_idx == IW'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/svc_soc_io_arbiter.sv
// Shares the SOC I/O register bus among NUM_REQ requesters.
// Ports: req_* per-requester commands, rsp_* completions, io_* downstream bus.
module svc_soc_io_arbiter
    import svc_soc_io_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = IO_AW,
    parameter int unsigned DW      = IO_DW,
    localparam int unsigned IW     = owner_w(NUM_REQ),
    localparam int unsigned SW     = DW / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    input  logic [NUM_REQ*SW-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  io_ren,
    output logic [AW-1:0]         io_raddr,
    input  logic [DW-1:0]         io_rdata,
    output logic                  io_wen,
    output logic [AW-1:0]         io_waddr,
    output logic [DW-1:0]         io_wdata,
    output logic [SW-1:0]         io_wstrb
);

    // The command bundle is sized by the package widths.
    if (AW != IO_AW || DW != IO_DW) begin : g_width_check
        $error("svc_soc_io_arbiter: AW/DW must match io_cmd_t");
    end

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      grant_idx;
    logic               accept;
    io_cmd_t            sel_cmd;

    logic          iss_vld_q, iss_vld_d;
    logic          iss_rd_q,  iss_rd_d;
    logic [IW-1:0] iss_own_q, iss_own_d;
    logic [AW-1:0] raddr_q,   raddr_d;
    logic [AW-1:0] waddr_q,   waddr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [SW-1:0] wstrb_q,   wstrb_d;
    logic          rsp_vld_q, rsp_vld_d;
    logic          rsp_rd_q,  rsp_rd_d;
    logic [IW-1:0] rsp_own_q, rsp_own_d;

    // No grant can be given while reset is held.
    assign arb_req   = req_valid & {NUM_REQ{rst_n}};
    assign req_ready = grant;
    assign accept    = |grant;

    svc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_cmd.write = req_write[i];
                sel_cmd.addr  = req_addr[i*AW +: AW];
                sel_cmd.wdata = req_wdata[i*DW +: DW];
                sel_cmd.wstrb = req_wstrb[i*SW +: SW];
            end
        end
    end

    // Address/data hold their last value between accepts.
    always_comb begin
        iss_vld_d = accept;
        iss_rd_d  = accept & ~sel_cmd.write;
        iss_own_d = accept ? grant_idx : iss_own_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        if (accept && !sel_cmd.write) begin
            raddr_d = sel_cmd.addr;
        end
        if (accept && sel_cmd.write) begin
            waddr_d = sel_cmd.addr;
            wdata_d = sel_cmd.wdata;
            wstrb_d = sel_cmd.wstrb;
        end
        rsp_vld_d = iss_vld_q;
        rsp_rd_d  = iss_rd_q;
        rsp_own_d = iss_own_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_vld_q <= 1'b0;
            iss_rd_q  <= 1'b0;
            iss_own_q <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_rd_q  <= 1'b0;
            rsp_own_q <= '0;
        end else begin
            iss_vld_q <= iss_vld_d;
            iss_rd_q  <= iss_rd_d;
            iss_own_q <= iss_own_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_rd_q  <= rsp_rd_d;
            rsp_own_q <= rsp_own_d;
        end
    end

    assign io_ren   = iss_vld_q & iss_rd_q;
    assign io_wen   = iss_vld_q & ~iss_rd_q;
    assign io_raddr = raddr_q;
    assign io_waddr = waddr_q;
    assign io_wdata = wdata_q;
    assign io_wstrb = wstrb_q;

    // io_rdata arrives the cycle after io_ren, i.e. in the response stage.
    assign rsp_valid = rsp_vld_q ? (NUM_REQ'(1) << rsp_own_q) : '0;
    assign rsp_rdata = (rsp_vld_q && rsp_rd_q) ? io_rdata : '0;

`ifndef SYNTHESIS
    a_ready_onehot0 : assert property (
        @(posedge clk) $onehot0(req_ready));
    a_rsp_onehot0 : assert property (
        @(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
    a_ren_wen_excl : assert property (
        @(posedge clk) disable iff (!rst_n) !(io_ren && io_wen));
`endif

endmodule

// File: tb/tb_svc_soc_io_arbiter.sv
// Scoreboard bench for svc_soc_io_arbiter with three requesters.
// Expected issue/response entries are queued at accept and popped on output.
module tb_svc_soc_io_arbiter;

    localparam int N = 3;

    typedef struct {
        int          cyc;
        int          own;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } sb_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N*4-1:0]  req_wstrb;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            io_ren;
    logic [31:0]     io_raddr;
    logic [31:0]     io_rdata;
    logic            io_wen;
    logic [31:0]     io_waddr;
    logic [31:0]     io_wdata;
    logic [3:0]      io_wstrb;

    svc_soc_io_arbiter #(
        .NUM_REQ (N),
        .AW      (32),
        .DW      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .io_ren    (io_ren),
        .io_raddr  (io_raddr),
        .io_rdata  (io_rdata),
        .io_wen    (io_wen),
        .io_waddr  (io_waddr),
        .io_wdata  (io_wdata),
        .io_wstrb  (io_wstrb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int  nvec = 0;
    int  nerr = 0;
    int  cyc  = 0;
    int  ptr  = 0;
    bit  rst_seen = 0;
    sb_t rq[N][$];
    sb_t iss_q[$];
    sb_t rsp_q[$];
    int  dlog[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    function automatic sb_t mk(bit wr, logic [31:0] a,
                               logic [31:0] d, logic [3:0] s);
        sb_t c;
        c.cyc = 0;
        c.own = 0;
        c.wr = wr;
        c.addr = a;
        c.wdata = d;
        c.strb = s;
        return c;
    endfunction

    function automatic bit busy();
        bit b;
        b = (iss_q.size() > 0) || (rsp_q.size() > 0);
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) b = 1;
        end
        return b;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_write[i] = rq[i][0].wr;
                req_addr[i*32 +: 32] = rq[i][0].addr;
                req_wdata[i*32 +: 32] = rq[i][0].wdata;
                req_wstrb[i*4 +: 4] = rq[i][0].strb;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        io_rdata = $urandom;
    endtask

    task automatic evaluate();
        logic [N-1:0] er;
        logic [N-1:0] erv;
        logic [31:0]  erd;
        int           win;
        bit           have;
        sb_t          e;
        sb_t          c;
        er  = '0;
        win = -1;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(ptr + k) % N]) begin
                    win = (ptr + k) % N;
                end
            end
        end
        if (win >= 0) er[win] = 1'b1;
        chk("req_ready", req_ready, er);
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) dlog.push_back(i);
        end

        have = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
        if (have) e = iss_q.pop_front();
        chk("io_ren", io_ren, have && !e.wr);
        chk("io_wen", io_wen, have && e.wr);
        if (have && !e.wr) chk("io_raddr", io_raddr, e.addr);
        if (have && e.wr) begin
            chk("io_waddr", io_waddr, e.addr);
            chk("io_wdata", io_wdata, e.wdata);
            chk("io_wstrb", io_wstrb, e.strb);
        end

        have = (rsp_q.size() > 0) && (rsp_q[0].cyc == cyc);
        if (have) e = rsp_q.pop_front();
        erv = have ? (N'(1) << e.own) : '0;
        erd = (have && !e.wr) ? io_rdata : 32'h0;
        chk("rsp_valid", rsp_valid, erv);
        chk("rsp_rdata", rsp_rdata, erd);

        if (win >= 0) begin
            c = rq[win].pop_front();
            c.own = win;
            c.cyc = cyc + 1;
            iss_q.push_back(c);
            c.cyc = cyc + 2;
            rsp_q.push_back(c);
            ptr = (win + 1) % N;
        end
        if (!rst_n) begin
            iss_q.delete();
            rsp_q.delete();
            ptr = 0;
        end
    endtask

    task automatic tick();
        drive();
        @(negedge clk);
        if (rst_seen) evaluate();
        @(posedge clk);
        cyc++;
        if (!rst_n) rst_seen = 1;
        #1;
    endtask

    task automatic run_idle(int maxc);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy(), 0);
    endtask

    int b;

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        req_wstrb = '0;
        io_rdata = '0;
        @(posedge clk);
        rst_seen = 1;
        #1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // contention: all valid from reset, two commands each
        b = dlog.size();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                rq[i].push_back(mk(r[0], 32'h1000 + 32'(i * 16 + r),
                                   32'hA0 + 32'(i), 4'hF));
            end
        end
        run_idle(40);
        chk("rr_cnt", dlog.size() - b, 6);
        for (int i = 0; i < 6; i++) begin
            chk("rr_order", dlog[b + i], i % N);
        end

        // single read from requester 1
        rq[1].push_back(mk(0, 32'h8000_0010, 32'h0, 4'h0));
        run_idle(20);

        // single write from requester 0
        rq[0].push_back(mk(1, 32'h8000_0000, 32'h0000_0001, 4'b0001));
        run_idle(20);

        // wrap: req2 moves the pointer to 0, idle, then req1+req0
        rq[2].push_back(mk(0, 32'h8000_0020, 32'h0, 4'h0));
        run_idle(20);
        repeat (3) tick();
        b = dlog.size();
        rq[1].push_back(mk(0, 32'h8000_0044, 32'h0, 4'h0));
        rq[0].push_back(mk(0, 32'h8000_0040, 32'h0, 4'h0));
        run_idle(20);
        chk("wrap_cnt", dlog.size() - b, 2);
        chk("wrap_first", dlog[b], 0);
        chk("wrap_second", dlog[b + 1], 1);

        // back-to-back read, write, read from requester 0
        rq[0].push_back(mk(0, 32'h8000_0100, 32'h0, 4'h0));
        rq[0].push_back(mk(1, 32'h8000_0104, 32'h1234_5678, 4'b1100));
        rq[0].push_back(mk(0, 32'h8000_0108, 32'h0, 4'h0));
        run_idle(20);

        // reset while io_ren is high
        rq[0].push_back(mk(0, 32'h8000_0200, 32'h0, 4'h0));
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        b = dlog.size();
        rq[0].push_back(mk(0, 32'h8000_0300, 32'h0, 4'h0));
        rq[1].push_back(mk(1, 32'h8000_0304, 32'hCAFE, 4'hF));
        run_idle(20);
        chk("rst_cnt", dlog.size() - b, 2);
        chk("rst_first", dlog[b], 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
